output_deserializer: RTL and testbench
======================================

// Module: output_deserializer
// PURPOSE
//   Inverse of the layer input serializer: collects a serial stream of neuron results
//   (one dataWidth word per valid cycle) into one parallel layer-output vector.
//   Sits between the neuron MAC/activation output and the next layer's parallel input bus.
//   First word received lands in the MSB slice, matching the serializer's MSB-first order.
//   Holds the completed vector with a valid/ready handshake until the consumer accepts it.
// PARAMETERS
//   numOutputs    16                   words per frame (>=2)
//   dataWidth     16                   bits per word
//   counterWidth  $clog2(numOutputs)   word-index counter width
// PORTS
//   clk                clock   1                         single clock, rising edge
//   reset              input   1                         asynchronous, active-high
//   start              input   1                         1-cycle pulse: clear buffer, begin a frame
//   dataValid          input   1                         deserializerIn holds a word this cycle
//   deserializerIn     input   dataWidth                 serial word in
//   outReady           input   1                         consumer accepts the frame
//   deserializerOut    output  dataWidth*numOutputs      assembled frame; word 0 at MSB slice
//   outValid           output  1                         frame complete and held
//   busy               output  1                         high in COLLECT
//   counterOut         output  counterWidth              index of next word to be written
//   overrun            output  1                         only with DESER_OVERRUN_EN
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, deserializerOut=0, counterOut=0,
//     outValid=0, busy=0, overrun=0. Reset mid-frame discards all partial data.
//   - FSM IDLE -> COLLECT -> DONE -> IDLE (or -> COLLECT).
//   - IDLE: start=1 -> next cycle COLLECT, deserializerOut=0, counterOut=0.
//     dataValid in IDLE is dropped.
//   - COLLECT: each cycle with dataValid=1, write deserializerIn into slice
//     [(numOutputs-1-counterOut)*dataWidth +: dataWidth], counterOut+1.
//     dataValid=0 cycles are gaps; no state change.
//   - Last word (dataValid with counterOut==numOutputs-1): counterOut wraps to 0,
//     next state DONE; outValid=1 on the cycle after the last word (latency 1).
//   - start in COLLECT (with or without dataValid): restart; buffer cleared,
//     counterOut=0, the concurrent word is dropped.
//   - DONE: outValid=1; deserializerOut and counterOut stable. outReady=1 ->
//     outValid=0 next cycle, state IDLE. start alone in DONE is ignored.
//   - start && outReady in DONE: frame accepted and new frame begins; next state
//     COLLECT, buffer cleared (back-to-back frames, no idle cycle).
//   - dataValid in DONE is dropped; the held frame is never modified.
//   - deserializerOut is registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   Macro DESER_OVERRUN_EN:
//   - Defined: port overrun exists; sticky, set next cycle when dataValid=1 in IDLE
//     or DONE, or with start in COLLECT; cleared by reset or by start (accepted).
//     Set and clear same cycle: clear wins.
//   - Undefined: no overrun port or register; dropped words are silent.
// STRUCTURE
//   - Shared package nn_pkg: state enum deser_state_t {IDLE, COLLECT, DONE};
//     default DATA_WIDTH and layer-size constants shared with the serializer.
//   - One sub-module natural: deser_word_counter (mod-numOutputs counter with
//     clear, increment and wrap flag); FSM and buffer stay in the top.
// TESTING (numOutputs=4, dataWidth=8 unless stated)
//   1. start; words 11,22,33,44 on consecutive cycles -> deserializerOut=32'h11223344,
//      outValid=1 the cycle after 44; outReady=1 -> outValid=0 next cycle.
//   2. Same words with 1-3 cycle dataValid gaps -> identical frame; counterOut steps 0..3 then 0.
//   3. outReady low 10 cycles in DONE with dataValid pulses -> output stable,
//      frame unchanged; overrun=1 with DESER_OVERRUN_EN, absent without.
//   4. start, words AA,BB, start again, then 01,02,03,04 -> frame 32'h01020304.
//   5. start && outReady in DONE, then 4 words -> second frame, no IDLE cycle.
//   6. Async reset asserted mid-COLLECT between clock edges -> all outputs 0 immediately.
//   7. Default params: 16 words 0x0000..0x000F -> word 0 in bits [255:240].

Source files
------------

// File: rtl/nn_pkg.sv
// Shared neural-network layer definitions used by the serializer/deserializer pair.
// Holds the deserializer state encoding and the default layer geometry.
package nn_pkg;

  // Default word width of neuron results on the layer streams.
  localparam int DATA_WIDTH    = 16;
  // Default number of neurons (words) per layer frame.
  localparam int LAYER_OUTPUTS = 16;

  // Deserializer frame-assembly states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } deser_state_t;

endpackage

// File: rtl/deser_word_counter.sv
// Modulo-numOutputs word index counter for the output deserializer.
// Clear has priority over increment; o_wrap flags the increment that rolls the
// index from numOutputs-1 back to 0 (i.e. the last word of a frame).
module deser_word_counter #(
  parameter int numOutputs   = 16,
  parameter int counterWidth = $clog2(numOutputs)
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    i_clr,
  input  logic                    i_inc,
  output logic [counterWidth-1:0] o_count,
  output logic                    o_wrap
);

  localparam logic [counterWidth-1:0] LAST_IDX = counterWidth'(numOutputs - 1);

  logic [counterWidth-1:0] r_count;

  assign o_wrap  = i_inc && (r_count == LAST_IDX);
  assign o_count = r_count;

  // Index register: clear, wrap to zero after the last word, otherwise step by one.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/output_deserializer.sv
// Output deserializer: assembles numOutputs serial neuron words (first word in the
// MSB slice) into one parallel frame and holds it under a valid/ready handshake.
// Optional feature macro: DESER_OVERRUN_EN adds a sticky overrun flag that records
// words dropped in IDLE/DONE or discarded by a restart.
module output_deserializer
  import nn_pkg::*;
#(
  parameter int numOutputs   = LAYER_OUTPUTS,
  parameter int dataWidth    = DATA_WIDTH,
  parameter int counterWidth = $clog2(numOutputs)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             dataValid,
  input  logic [dataWidth-1:0]             deserializerIn,
  input  logic                             outReady,
  output logic [dataWidth*numOutputs-1:0]  deserializerOut,
  output logic                             outValid,
  output logic                             busy,
  output logic [counterWidth-1:0]          counterOut
`ifdef DESER_OVERRUN_EN
  ,
  output logic                             overrun
`endif
);

  deser_state_t                    r_state;
  deser_state_t                    w_state_next;
  logic [dataWidth*numOutputs-1:0] r_frame;
  logic [counterWidth-1:0]         w_count;
  logic                            w_clear;
  logic                            w_write;
  logic                            w_last;

  // An accepted start clears the buffer; start in DONE only counts with outReady.
  assign w_clear = start && ((r_state == IDLE) || (r_state == COLLECT) ||
                             ((r_state == DONE) && outReady));
  // A word is stored only in COLLECT and only when no restart drops it.
  assign w_write = (r_state == COLLECT) && dataValid && !start;

  deser_word_counter #(
    .numOutputs  (numOutputs),
    .counterWidth(counterWidth)
  ) u_counter (
    .clk    (clk),
    .i_reset(reset),
    .i_clr  (w_clear),
    .i_inc  (w_write),
    .o_count(w_count),
    .o_wrap (w_last)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: restart wins over data, last word moves to DONE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = COLLECT;
      end
      COLLECT: begin
        if (!start && w_last) w_state_next = DONE;
      end
      DONE: begin
        if (outReady) w_state_next = start ? COLLECT : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Frame buffer: cleared on accepted start, word k written to slice numOutputs-1-k.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame <= '0;
    end else if (w_clear) begin
      r_frame <= '0;
    end else if (w_write) begin
      for (int k = 0; k < numOutputs; k++) begin
        if (w_count == counterWidth'(k)) begin
          r_frame[(numOutputs-1-k)*dataWidth +: dataWidth] <= deserializerIn;
        end
      end
    end
  end

  assign deserializerOut = r_frame;
  assign outValid        = (r_state == DONE);
  assign busy            = (r_state == COLLECT);
  assign counterOut      = w_count;

`ifdef DESER_OVERRUN_EN
  logic r_overrun;
  logic w_overrun_set;

  // Words arriving outside COLLECT, or alongside a restart, are lost.
  assign w_overrun_set = dataValid && ((r_state != COLLECT) || start);

  // Sticky overrun flag; an accepted start clears it and beats a same-cycle set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_clear) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

endmodule

// File: tb/tb_output_deserializer.sv
// Self-checking bench for output_deserializer (4x8 instance plus a default 16x16 one).
// A queue-based frame model predicts every output after every clock.
module tb_output_deserializer;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, dataValid, outReady;
  logic [7:0]  din;
  logic [31:0] dout;
  logic        ov, bsy;
  logic [1:0]  cnt;

  logic         b_start, b_dv, b_rdy;
  logic [15:0]  b_din;
  logic [255:0] b_dout;
  logic         b_ov, b_busy;
  logic [3:0]   b_cnt;

`ifdef DESER_OVERRUN_EN
  logic ovr, b_ovr;
`endif

  output_deserializer #(.numOutputs(N), .dataWidth(W)) dut (
    .clk(clk), .reset(reset), .start(start), .dataValid(dataValid),
    .deserializerIn(din), .outReady(outReady), .deserializerOut(dout),
    .outValid(ov), .busy(bsy), .counterOut(cnt)
`ifdef DESER_OVERRUN_EN
    , .overrun(ovr)
`endif
  );

  output_deserializer dut_big (
    .clk(clk), .reset(reset), .start(b_start), .dataValid(b_dv),
    .deserializerIn(b_din), .outReady(b_rdy), .deserializerOut(b_dout),
    .outValid(b_ov), .busy(b_busy), .counterOut(b_cnt)
`ifdef DESER_OVERRUN_EN
    , .overrun(b_ovr)
`endif
  );

  // Behavioural model: words received so far in the current/last frame.
  int m_words[$];
  bit m_coll, m_held, m_ovr;
  int total = 0;
  int bad   = 0;
  int stepno = 0;

  function automatic logic [31:0] m_frame();
    logic [31:0] f;
    f = 32'h0;
    for (int i = 0; i < m_words.size(); i++)
      f = f | (32'(m_words[i]) << ((N - 1 - i) * W));
    return f;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_words.delete();
    m_coll = 0;
    m_held = 0;
    m_ovr  = 0;
  endtask

  task automatic model_step(input logic s, input logic dv, input logic [7:0] d, input logic rdy);
    bit acc, set;
    acc   = s && (!m_held || rdy);
    set   = dv && (!m_coll || s);
    m_ovr = acc ? 1'b0 : (m_ovr | set);
    if (m_coll) begin
      if (s) m_words.delete();
      else if (dv) begin
        m_words.push_back(int'(d));
        if (m_words.size() == N) begin
          m_coll = 0;
          m_held = 1;
        end
      end
    end else if (m_held) begin
      if (rdy) begin
        m_held = 0;
        if (s) begin
          m_coll = 1;
          m_words.delete();
        end
      end
    end else if (s) begin
      m_coll = 1;
      m_words.delete();
    end
  endtask

  task automatic check_all();
    check("frame", dout, m_frame());
    check("outValid", ov, m_held);
    check("busy", bsy, m_coll);
    check("counter", cnt, m_words.size() % N);
`ifdef DESER_OVERRUN_EN
    check("overrun", ovr, m_ovr);
`endif
  endtask

  // One clock of stimulus: drive, advance model, sample 1 ns after the edge.
  task automatic step(input logic s, input logic dv, input logic [7:0] d, input logic rdy);
    start = s; dataValid = dv; din = d; outReady = rdy;
    model_step(s, dv, d, rdy);
    @(posedge clk); #1;
    stepno++;
    $display("step %0d start=%0b dv=%0b din=%02h rdy=%0b -> out=%08h valid=%0b busy=%0b cnt=%0d",
             stepno, s, dv, d, rdy, dout, ov, bsy, cnt);
    check_all();
  endtask

  initial begin
    logic [7:0]   wl [4];
    logic [255:0] big_exp;

    reset = 1'b1; start = 0; dataValid = 0; din = 0; outReady = 0;
    b_start = 0; b_dv = 0; b_din = 0; b_rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    #1;
    check_all();

    // 1: back-to-back words
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h11, 0); step(0, 1, 8'h22, 0); step(0, 1, 8'h33, 0); step(0, 1, 8'h44, 0);
    check("t1_frame", dout, 32'h11223344);
    check("t1_valid", ov, 1'b1);
    step(0, 0, 8'h00, 1);
    check("t1_valid_drop", ov, 1'b0);

    // 2: same words with random gaps
    wl[0] = 8'h11; wl[1] = 8'h22; wl[2] = 8'h33; wl[3] = 8'h44;
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(1, 3)) step(0, 0, 8'($urandom), 0);
      step(0, 1, wl[i], 0);
    end
    check("t2_frame", dout, 32'h11223344);
    step(0, 0, 8'h00, 1);

    // 3: hold in DONE with dataValid pulses
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'hA1, 0); step(0, 1, 8'hB2, 0); step(0, 1, 8'hC3, 0); step(0, 1, 8'hD4, 0);
    for (int i = 0; i < 10; i++) begin
      step((i == 4) ? 1'b1 : 1'b0, i[0], 8'($urandom), 0);
      check("t3_hold", dout, 32'hA1B2C3D4);
      check("t3_valid", ov, 1'b1);
    end
`ifdef DESER_OVERRUN_EN
    check("t3_overrun", ovr, 1'b1);
`endif
    step(0, 0, 8'h00, 1);

    // 4: restart mid-frame
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'hAA, 0); step(0, 1, 8'hBB, 0);
    step(1, 0, 8'h00, 0);
    check("t4_cleared", dout, 32'h0);
    step(0, 1, 8'h01, 0); step(0, 1, 8'h02, 0); step(0, 1, 8'h03, 0); step(0, 1, 8'h04, 0);
    check("t4_frame", dout, 32'h01020304);

    // 5: accept and restart in the same cycle
    step(1, 0, 8'h00, 1);
    check("t5_busy", bsy, 1'b1);
    step(0, 1, 8'h05, 0); step(0, 1, 8'h06, 0); step(0, 1, 8'h07, 0); step(0, 1, 8'h08, 0);
    check("t5_frame", dout, 32'h05060708);
    step(0, 0, 8'h00, 1);

    // 6: async reset mid-COLLECT, between edges
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h5A, 0); step(0, 1, 8'hA5, 0);
    start = 0; dataValid = 0;
    #3 reset = 1'b1;
    #1;
    check("t6_frame", dout, 32'h0);
    check("t6_busy", bsy, 1'b0);
    check("t6_cnt", cnt, 2'd0);
    check("t6_valid", ov, 1'b0);
`ifdef DESER_OVERRUN_EN
    check("t6_overrun", ovr, 1'b0);
`endif
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    check_all();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
           8'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    // 7: default geometry, 16 words 0..15
    big_exp = '0;
    for (int i = 0; i < 16; i++) big_exp = (big_exp << 16) | 256'(i);
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    b_dv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b_din = 16'(i);
      check("t7_cnt", b_cnt, 256'(i));
      @(posedge clk); #1;
    end
    b_dv = 1'b0;
    $display("big frame %064h valid=%0b", b_dout, b_ov);
    check("t7_frame", b_dout, big_exp);
    check("t7_msb", b_dout[255:240], 16'h0000);
    check("t7_lsb", b_dout[15:0], 16'h000F);
    check("t7_valid", b_ov, 1'b1);
    b_rdy = 1'b1;
    @(posedge clk); #1;
    b_rdy = 1'b0;
    check("t7_accept", b_ov, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
